// File: rtl/fft_clip_cfg_pkg.sv
// Shared types and constants for the fft_word_clip configuration sequencer:
// FSM states, AXI response codes and the err_code encoding.
package fft_clip_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RESP     = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_hs_timer.sv
// Per-state handshake watchdog: cleared on restart, counts up and saturates
// once the state has been occupied for TIMEOUT_CYC cycles.
module axi_lite_hs_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: restart wins, otherwise count up to the limit and hold.
    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = 8'd0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/fft_clip_cfg_sequencer.sv
// AXI4-Lite master that writes a configuration vector into the fft_word_clip
// register bank, reads every register back and reports the first failure.
module fft_clip_cfg_sequencer
    import fft_clip_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [32*NUM_REGS-1:0]  cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              err_index,
    output logic [1:0]              err_code,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          error_q;
    logic [3:0]    err_index_q;
    logic [1:0]    err_code_q;
    logic [511:0]  shadow_q;

    logic [31:0]           shadow_word_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  accept_s, aw_hs_s, w_hs_s, expired_s, restart_s;
    logic                  fail_s;
    logic [1:0]            fail_code_s;

    assign accept_s      = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    assign aw_hs_s       = m_axi_awvalid && m_axi_awready;
    assign w_hs_s        = m_axi_wvalid && m_axi_wready;
    assign restart_s     = (state_d != state_q);
    assign shadow_word_s = shadow_q[{idx_q, 5'b00000} +: 32];
    assign addr_s        = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({idx_q, 2'b00});

    axi_lite_hs_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .restart_i (restart_s),
        .expired_o (expired_s)
    );

    // Sequencing: write phase, then readback phase; any failure goes to FIN.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        fail_s      = 1'b0;
        fail_code_s = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    state_d   = ST_WR_REQ;
                    idx_d     = 4'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs_s;
                w_done_d  = w_done_q | w_hs_s;
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (expired_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_TIMEOUT;
                    state_d     = ST_FIN;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (resp_is_err(m_axi_bresp)) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_RESP;
                        state_d     = ST_FIN;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_WR_REQ;
                    end
                end else if (expired_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_TIMEOUT;
                    state_d     = ST_FIN;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    state_d = ST_RD_DATA;
                end else if (expired_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_TIMEOUT;
                    state_d     = ST_FIN;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    if (resp_is_err(m_axi_rresp)) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_RESP;
                        state_d     = ST_FIN;
                    end else if (m_axi_rdata != shadow_word_s) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_MISMATCH;
                        state_d     = ST_FIN;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_RD_REQ;
                    end
                end else if (expired_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_TIMEOUT;
                    state_d     = ST_FIN;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, index and per-channel write handshake flags.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Shadow copy of cfg_data and sticky first-failure status.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            shadow_q    <= 512'd0;
            error_q     <= 1'b0;
            err_index_q <= 4'd0;
            err_code_q  <= ERR_NONE;
        end else if (accept_s) begin
            shadow_q    <= 512'(cfg_data);
            error_q     <= 1'b0;
            err_index_q <= 4'd0;
            err_code_q  <= ERR_NONE;
        end else if (fail_s) begin
            error_q     <= 1'b1;
            err_index_q <= idx_q;
            err_code_q  <= fail_code_s;
        end else begin
            error_q <= error_q;
        end
    end

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done          = (state_q == ST_FIN);
    assign error         = error_q;
    assign err_index     = err_index_q;
    assign err_code      = err_code_q;
    assign m_axi_awaddr  = addr_s;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_axi_wdata   = shadow_word_s;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_axi_bready  = (state_q == ST_WR_RESP);
    assign m_axi_araddr  = addr_s;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == ST_RD_REQ);
    assign m_axi_rready  = (state_q == ST_RD_DATA);

endmodule
